inv_batch_feeder: RTL and testbench

- Upstream front-end for the multi-element Montgomery inverter (Mont_inv_multi).
- Collects individual inversion requests (operand plus destination address) into a FIFO.
- Groups the requests into batches and replays each batch to the inverter using its start/write protocol: I_START held high while one address/data pair is presented per cycle.
- Serialises batches against the inverter's O_BUSY, so a new batch is never issued while an inversion is in flight.

---
 rtl/inv_batch_feeder_pkg.sv | 24 ++
 rtl/inv_batch_feeder_sync_fifo.sv | 58 +++++
 rtl/inv_batch_feeder.sv | 168 ++++++++++++++++
 tb/tb_inv_batch_feeder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_batch_feeder_pkg.sv
// Shared types for the Montgomery inverter batch feeder: operand type, request record,
// feeder FSM states and default batching constants.
package inv_batch_feeder_pkg;

  typedef logic [255:0] M_tilde12_t;

  localparam int INV_AW           = 9;
  localparam int FEEDER_DEPTH     = 16;
  localparam int FEEDER_MAX_BATCH = 8;
  localparam int FEEDER_TIMEOUT   = 64;

  typedef struct packed {
    logic [INV_AW-1:0] addr;
    M_tilde12_t        data;
  } inv_req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } feeder_state_e;

endpackage

// File: rtl/inv_batch_feeder_sync_fifo.sv
// Request queue: DEPTH x W storage, head visible combinationally, push/pop same cycle legal.
// Zero-latency read of the head; caller must not push when full or pop when empty.
module inv_batch_feeder_sync_fifo
  import inv_batch_feeder_pkg::*;
#(
  parameter int W     = $bits(inv_req_t),
  parameter int DEPTH = FEEDER_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop)  rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_dat;
  end

  assign head_dat = mem_q[rd_q];
  assign cnt      = cnt_q;

endmodule

// File: rtl/inv_batch_feeder.sv
// Batches queued inversion requests and replays them to the inverter as one I_START burst.
// First element one cycle after the issue decision; upstream stalls on full FIFO, batches wait on busy.
module inv_batch_feeder
  import inv_batch_feeder_pkg::*;
#(
  parameter int DEPTH     = FEEDER_DEPTH,
  parameter int MAX_BATCH = FEEDER_MAX_BATCH,
  parameter int TIMEOUT   = FEEDER_TIMEOUT,
  parameter int AW        = INV_AW,
  parameter int DW        = $bits(M_tilde12_t)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     I_REQ_VALID,
  input  logic [AW-1:0]            I_REQ_ADDR,
  input  logic [DW-1:0]            I_REQ_DATA,
  output logic                     O_REQ_READY,
  input  logic                     I_FLUSH,
  output logic                     O_INV_START,
  output logic [AW-1:0]            O_INV_WADDR,
  output logic [DW-1:0]            O_INV_WDATA,
  input  logic                     I_INV_BUSY,
  output logic [3:0]               O_BATCH_LEN,
  output logic                     O_BATCH_DONE,
  output logic [$clog2(DEPTH):0]   O_FIFO_CNT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAXB_C   = CW'(MAX_BATCH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  req_t          push_req;
  req_t          head_req;
  logic          push;
  logic          pop;
  logic [CW-1:0] cnt;
  logic [CW-1:0] batch_len;
  logic          go;

  feeder_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [1:0]    ack_q, ack_d;
  logic          start_q, start_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    len_q, len_d;
  logic          done_q, done_d;

  assign push_req    = '{addr: I_REQ_ADDR, data: I_REQ_DATA};
  assign O_REQ_READY = rstn & (cnt != DEPTH_C);
  assign push        = I_REQ_VALID & O_REQ_READY;

  inv_batch_feeder_sync_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_dat (push_req),
    .pop      (pop),
    .head_dat (head_req),
    .cnt      (cnt)
  );

  assign batch_len = (cnt > MAXB_C) ? MAXB_C : cnt;
  assign go = (state_q == S_IDLE) && !I_INV_BUSY && (cnt != '0) &&
              ((cnt >= MAXB_C) || I_FLUSH || (tmo_q >= TMO_LAST));

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    rem_d   = rem_q;
    ack_d   = ack_q;
    start_d = start_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          // The decision cycle already pops and registers the first element.
          pop     = 1'b1;
          start_d = 1'b1;
          waddr_d = head_req.addr;
          wdata_d = head_req.data;
          len_d   = 4'(batch_len);
          rem_d   = batch_len - CW'(1);
          tmo_d   = '0;
          state_d = S_ISSUE;
        end else if (cnt == '0) begin
          tmo_d = '0;
        end else if (tmo_q < TMO_LAST) begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_ISSUE: begin
        if (rem_q != '0) begin
          pop     = 1'b1;
          waddr_d = head_req.addr;
          wdata_d = head_req.data;
          rem_d   = rem_q - CW'(1);
        end else begin
          start_d = 1'b0;
          ack_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // A fast single-element inverter may never show busy; give up after four cycles.
        if (I_INV_BUSY || (ack_q == 2'd3)) begin
          state_d = S_WAIT_DONE;
        end else begin
          ack_d = ack_q + 2'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!I_INV_BUSY) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      rem_q   <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      rem_q   <= rem_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign O_INV_START  = start_q;
  assign O_INV_WADDR  = waddr_q;
  assign O_INV_WDATA  = wdata_q;
  assign O_BATCH_LEN  = len_q;
  assign O_BATCH_DONE = done_q;
  assign O_FIFO_CNT   = cnt;

endmodule

// File: tb/tb_inv_batch_feeder.sv
// Directed bench for inv_batch_feeder: reset, full batch, timeout, flush, back-pressure, reset mid-burst.
`timescale 1ns/1ps
module tb_inv_batch_feeder;
  import inv_batch_feeder_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         I_REQ_VALID = 1'b0;
  logic [8:0]   I_REQ_ADDR = '0;
  logic [255:0] I_REQ_DATA = '0;
  logic         O_REQ_READY;
  logic         I_FLUSH = 1'b0;
  logic         O_INV_START;
  logic [8:0]   O_INV_WADDR;
  logic [255:0] O_INV_WDATA;
  logic         I_INV_BUSY;
  logic [3:0]   O_BATCH_LEN;
  logic         O_BATCH_DONE;
  logic [4:0]   O_FIFO_CNT;

  logic busy_force = 1'b0;
  logic busy_model = 1'b0;
  bit   model_en   = 1'b0;
  assign I_INV_BUSY = busy_force | busy_model;

  inv_batch_feeder dut (
    .clk          (clk),
    .rstn         (rstn),
    .I_REQ_VALID  (I_REQ_VALID),
    .I_REQ_ADDR   (I_REQ_ADDR),
    .I_REQ_DATA   (I_REQ_DATA),
    .O_REQ_READY  (O_REQ_READY),
    .I_FLUSH      (I_FLUSH),
    .O_INV_START  (O_INV_START),
    .O_INV_WADDR  (O_INV_WADDR),
    .O_INV_WDATA  (O_INV_WDATA),
    .I_INV_BUSY   (I_INV_BUSY),
    .O_BATCH_LEN  (O_BATCH_LEN),
    .O_BATCH_DONE (O_BATCH_DONE),
    .O_FIFO_CNT   (O_FIFO_CNT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_len = 0;
  int done_cnt = 0;
  int burst_q[$];
  int start_cyc_q[$];
  logic [8:0]   got_addr[$];
  logic [255:0] got_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Records every issued element, burst lengths, burst start cycles and done pulses.
  always @(negedge clk) begin
    if (!rstn) begin
      run_len <= 0;
    end else begin
      if (O_INV_START) begin
        if (run_len == 0) start_cyc_q.push_back(cyc);
        got_addr.push_back(O_INV_WADDR);
        got_data.push_back(O_INV_WDATA);
        run_len <= run_len + 1;
      end else if (run_len != 0) begin
        burst_q.push_back(run_len);
        run_len <= 0;
      end
      if (O_BATCH_DONE) done_cnt <= done_cnt + 1;
    end
  end

  // Inverter model: busy rises two cycles after a burst ends and lasts six cycles.
  initial begin
    forever begin
      @(negedge O_INV_START);
      if (model_en && rstn) begin
        repeat (2) @(posedge clk);
        #1 busy_model = 1'b1;
        repeat (6) @(posedge clk);
        #1 busy_model = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_req(input logic [8:0] a, input logic [255:0] d);
    int n = 0;
    I_REQ_VALID = 1'b1;
    I_REQ_ADDR  = a;
    I_REQ_DATA  = d;
    while (!O_REQ_READY && n < 200) begin
      tick();
      n++;
    end
    chk("push_accept", O_REQ_READY, 1);
    tick();
    I_REQ_VALID = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input int budget);
    int k = 0;
    while (burst_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("burst_count", burst_q.size(), n);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      tick();
      k++;
    end
    chk("done_count", done_cnt, n);
  endtask

  typedef struct {
    logic [8:0]   addr;
    logic [255:0] data;
    logic [8:0]   exp_addr;
    logic [255:0] exp_data;
  } vec_t;

  vec_t vec [8];

  initial begin
    int b0, d0, a0, s0, st0, st1, n;

    for (int i = 0; i < 8; i++) begin
      vec[i].addr     = 9'h011 + 9'(i);
      vec[i].data     = {8'hD0 + 8'(i), 216'h0, 32'hCAFE_0000 + 32'(i)};
      vec[i].exp_addr = 9'h011 + 9'(i);
      vec[i].exp_data = {8'hD0 + 8'(i), 216'h0, 32'hCAFE_0000 + 32'(i)};
    end

    // Reset and idle
    #50;
    chk("rst_start", O_INV_START, 0);
    chk("rst_cnt", O_FIFO_CNT, 0);
    chk("rst_ready_low", O_REQ_READY, 0);
    #50 rstn = 1'b1;
    #1;
    chk("rel_ready", O_REQ_READY, 1);
    chk("rel_start", O_INV_START, 0);
    chk("rel_waddr", O_INV_WADDR, 0);
    chk("rel_wdata", O_INV_WDATA, 0);
    chk("rel_len", O_BATCH_LEN, 0);
    chk("rel_done", O_BATCH_DONE, 0);
    chk("rel_cnt", O_FIFO_CNT, 0);
    repeat (200) tick();
    chk("idle_no_start", start_cyc_q.size(), 0);

    // Full batch of MAX_BATCH, table-driven
    model_en = 1'b1;
    b0 = burst_q.size(); d0 = done_cnt; a0 = got_addr.size(); st0 = start_cyc_q.size();
    for (int i = 0; i < 8; i++) push_req(vec[i].addr, vec[i].data);
    s0 = cyc;
    wait_bursts(b0 + 1, 50);
    chk("full_latency", start_cyc_q[st0], s0 + 1);
    chk("full_burst_len", burst_q[b0], 8);
    chk("full_batch_len", O_BATCH_LEN, 8);
    for (int i = 0; i < 8; i++) begin
      chk("full_addr", got_addr[a0 + i], vec[i].exp_addr);
      chk("full_data", got_data[a0 + i], vec[i].exp_data);
    end
    wait_done(d0 + 1, 40);
    repeat (5) tick();
    chk("full_done_once", done_cnt, d0 + 1);
    chk("full_cnt_empty", O_FIFO_CNT, 0);

    // Timeout-forced partial batch
    b0 = burst_q.size(); d0 = done_cnt; a0 = got_addr.size(); st0 = start_cyc_q.size();
    push_req(9'h022, 256'h2222);
    s0 = cyc;
    push_req(9'h023, 256'h2323);
    wait_bursts(b0 + 1, 100);
    chk("tmo_start_cycle", start_cyc_q[st0], s0 + 64);
    chk("tmo_burst_len", burst_q[b0], 2);
    chk("tmo_batch_len", O_BATCH_LEN, 2);
    chk("tmo_addr0", got_addr[a0], 9'h022);
    chk("tmo_addr1", got_addr[a0 + 1], 9'h023);
    chk("tmo_data1", got_data[a0 + 1], 256'h2323);
    wait_done(d0 + 1, 40);

    // Flush of a partial batch, then flush of an empty FIFO
    b0 = burst_q.size(); d0 = done_cnt; a0 = got_addr.size(); st0 = start_cyc_q.size();
    push_req(9'h031, 256'h31);
    push_req(9'h032, 256'h32);
    push_req(9'h033, 256'h33);
    tick();
    I_FLUSH = 1'b1;
    tick();
    I_FLUSH = 1'b0;
    s0 = cyc;
    wait_bursts(b0 + 1, 20);
    chk("flush_start_cycle", start_cyc_q[st0], s0);
    chk("flush_burst_len", burst_q[b0], 3);
    chk("flush_batch_len", O_BATCH_LEN, 3);
    chk("flush_addr2", got_addr[a0 + 2], 9'h033);
    wait_done(d0 + 1, 40);
    st1 = start_cyc_q.size();
    I_FLUSH = 1'b1;
    tick();
    I_FLUSH = 1'b0;
    repeat (20) tick();
    chk("empty_flush_ignored", start_cyc_q.size(), st1);

    // Back-pressure while busy, then drain in three batches
    busy_force = 1'b1;
    b0 = burst_q.size(); d0 = done_cnt; a0 = got_addr.size(); st0 = start_cyc_q.size();
    for (int i = 0; i < 16; i++) push_req(9'h040 + 9'(i), 256'h4000 + 256'(i));
    chk("bp_cnt_full", O_FIFO_CNT, 16);
    chk("bp_ready_low", O_REQ_READY, 0);
    I_REQ_VALID = 1'b1;
    I_REQ_ADDR  = 9'h050;
    I_REQ_DATA  = 256'h4010;
    repeat (5) tick();
    chk("bp_stalled_cnt", O_FIFO_CNT, 16);
    chk("bp_no_start_busy", start_cyc_q.size(), st0);
    busy_force = 1'b0;
    n = 0;
    while (!O_REQ_READY && n < 50) begin
      tick();
      n++;
    end
    chk("bp_ready_return", O_REQ_READY, 1);
    tick();
    I_REQ_VALID = 1'b0;
    wait_bursts(b0 + 3, 400);
    chk("bp_len0", burst_q[b0], 8);
    chk("bp_len1", burst_q[b0 + 1], 8);
    chk("bp_len2", burst_q[b0 + 2], 1);
    for (int i = 0; i < 17; i++) begin
      chk("bp_order_addr", got_addr[a0 + i], 9'h040 + 9'(i));
      chk("bp_order_data", got_data[a0 + i], 256'h4000 + 256'(i));
    end
    wait_done(d0 + 3, 100);

    // Reset on the third ISSUE cycle
    model_en = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < 8; i++) push_req(9'h060 + 9'(i), 256'h6000 + 256'(i));
    n = 0;
    while (!O_INV_START && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("mid_in_burst", O_INV_START, 1);
    d0 = done_cnt; b0 = burst_q.size();
    rstn = 1'b0;
    #1;
    chk("mid_start_cleared", O_INV_START, 0);
    chk("mid_cnt_cleared", O_FIFO_CNT, 0);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (30) tick();
    chk("mid_no_done", done_cnt, d0);
    chk("mid_no_burst", burst_q.size(), b0);
    chk("mid_cnt_after", O_FIFO_CNT, 0);
    chk("mid_ready_after", O_REQ_READY, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
